// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by every pipeline stage register and by the stage
// decoders that read the control bus.
//   - pipe_state_e : occupancy of a skid-buffered stage (empty / one / two entries)
//   - Ctrl*        : bit positions of the control fields inside the ctrl bus
//   - Alu*, F3*, F7*, Op* : ALU operation codes and RISC-V instruction encodings,
//                    kept here so every stage decodes ctrl the same way
package pipe_pkg;

    // Occupancy of a stage with a skid buffer.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

    // Control bus layout (24 bits in the reference processor).
    localparam int unsigned CtrlW        = 24;
    localparam int unsigned CtrlMemWrite = 0;
    localparam int unsigned CtrlMemRead  = 1;
    localparam int unsigned CtrlRegWrite = 2;
    localparam int unsigned CtrlMemtoReg = 3;
    localparam int unsigned CtrlBranch   = 4;
    localparam int unsigned CtrlJump     = 5;
    localparam int unsigned CtrlJalr     = 6;
    localparam int unsigned CtrlAluSrc   = 7;
    localparam int unsigned CtrlAluOpLsb = 8;
    localparam int unsigned CtrlAluOpW   = 4;
    localparam int unsigned CtrlWmaskLsb = 12;
    localparam int unsigned CtrlWmaskW   = 8;
    // Bits 20..23 are reserved and travel through the stage untouched.

    // ALU operation codes carried in the AluOp field.
    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluXor   = 4'd4;
    localparam logic [3:0] AluSll   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluSlt   = 4'd8;
    localparam logic [3:0] AluSltu  = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    // funct3 encodings.
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Beq    = 3'b000;
    localparam logic [2:0] F3Bne    = 3'b001;
    localparam logic [2:0] F3Blt    = 3'b100;
    localparam logic [2:0] F3Bge    = 3'b101;
    localparam logic [2:0] F3Bltu   = 3'b110;
    localparam logic [2:0] F3Bgeu   = 3'b111;

    // funct7 encodings.
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // Major opcodes.
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpOp32    = 7'b0111011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;

    // Extract the ALU operation from a control word.
    function automatic logic [CtrlAluOpW-1:0] ctrl_alu_op(input logic [CtrlW-1:0] ctrl);
        return ctrl[CtrlAluOpLsb +: CtrlAluOpW];
    endfunction

    // Extract the store byte mask from a control word.
    function automatic logic [CtrlWmaskW-1:0] ctrl_wmask(input logic [CtrlW-1:0] ctrl);
        return ctrl[CtrlWmaskLsb +: CtrlWmaskW];
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry storage for a pipeline stage with a registered
// upstream ready. A main register drives the outputs; a skid register catches
// the one entry that may arrive in the cycle the stage fills, because the
// upstream only sees the ready drop one cycle late.
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      discard every held entry at the next edge
//   in_valid_i / in_ready_o / in_data_i / in_ctrl_i      upstream handshake
//   out_valid_o / out_ready_i / out_data_o / out_ctrl_o  downstream handshake
// out_ctrl_o is the raw head control word; bubble masking is done by the caller.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DataW = 192,
    parameter int unsigned CtrlW = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DataW-1:0] in_data_i,
    input  logic [CtrlW-1:0] in_ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_data_o,
    output logic [CtrlW-1:0] out_ctrl_o
);

    pipe_state_e      state_q;
    logic             in_ready_q;
    logic [DataW-1:0] main_data_q;
    logic [CtrlW-1:0] main_ctrl_q;
    logic [DataW-1:0] skid_data_q;
    logic [CtrlW-1:0] skid_ctrl_q;

    logic accept;
    logic rel;

    assign accept = in_valid_i & in_ready_q & ~flush_i;
    assign rel    = (state_q != StEmpty) & out_ready_i & ~flush_i;

    // in_ready_q always tracks "next state is not full", so it is a pure register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush_i) begin
            // Data registers keep their contents; only occupancy is dropped.
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q     <= StOne;
                        main_data_q <= in_data_i;
                        main_ctrl_q <= in_ctrl_i;
                    end
                end
                StOne: begin
                    if (accept && !rel) begin
                        state_q     <= StTwo;
                        in_ready_q  <= 1'b0;
                        skid_data_q <= in_data_i;
                        skid_ctrl_q <= in_ctrl_i;
                    end else if (accept && rel) begin
                        main_data_q <= in_data_i;
                        main_ctrl_q <= in_ctrl_i;
                    end else if (rel) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a release can happen.
                    if (rel) begin
                        state_q     <= StOne;
                        in_ready_q  <= 1'b1;
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = main_ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register of the pipelined processor.
// Carries a payload bus and a control bus with a valid/ready handshake, a
// synchronous flush that inserts a bubble, and a saturating stall counter.
//   DATA_W / CTRL_W  payload and control widths
//   SKID             1: two-entry skid buffer, registered in_ready
//                    0: single register, combinational in_ready
//   CNT_W            stall counter width
// Ports:
//   clk, rst (synchronous, active-high), flush
//   in_valid / in_ready / in_data / in_ctrl        upstream side
//   out_valid / out_ready / out_data / out_ctrl    downstream side
//   stall_cnt        cycles with out_valid=1 and out_ready=0, saturating
// out_ctrl is forced to zero whenever out_valid is low; out_data is not cleared
// and must be qualified with out_valid.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 192,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic              ready_int;

    if (SKID != 0) begin : g_skid
        pipe_skid_buf #(
            .DataW (DATA_W),
            .CtrlW (CTRL_W)
        ) u_skid_buf (
            .clk_i       (clk),
            .rst_i       (rst),
            .flush_i     (flush),
            .in_valid_i  (in_valid),
            .in_ready_o  (ready_int),
            .in_data_i   (in_data),
            .in_ctrl_i   (in_ctrl),
            .out_valid_o (head_valid),
            .out_ready_i (out_ready),
            .out_data_o  (head_data),
            .out_ctrl_o  (head_ctrl)
        );
    end else begin : g_single
        logic              valid_q;
        logic [DATA_W-1:0] data_q;
        logic [CTRL_W-1:0] ctrl_q;
        logic              accept;
        logic              rel;

        // Ready follows the downstream in the same cycle when the register is full.
        assign ready_int = ~valid_q | out_ready;
        assign accept    = in_valid & ready_int & ~flush;
        assign rel       = valid_q & out_ready & ~flush;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ctrl_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
                ctrl_q  <= in_ctrl;
            end else if (rel) begin
                valid_q <= 1'b0;
            end
        end

        assign head_valid = valid_q;
        assign head_data  = data_q;
        assign head_ctrl  = ctrl_q;
    end

    assign in_ready  = ready_int;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    // Bubbles never carry live control bits downstream.
    assign out_ctrl  = head_valid ? head_ctrl : '0;

    logic [CNT_W-1:0] stall_cnt_q;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (head_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [CW-1:0] a_out_ctrl;
    logic [15:0]   a_stall_cnt;

    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [15:0]   b_stall_cnt;

    logic          c_in_ready, c_out_valid;
    logic [DW-1:0] c_out_data;
    logic [CW-1:0] c_out_ctrl;
    logic [3:0]    c_stall_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall_cnt)
    );

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        logic [15:0]   cnt;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [DW-1:0] od, input logic [CW-1:0] oc,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.oc = oc; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    endtask

    // Rows present inputs for one cycle and compare outputs before the edge.
    task automatic run_row(input vec_t v, input bit use_b, input string tag, input int idx);
        logic          ir, ov;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        logic [15:0]   cnt;
        drive(v.rst, v.flush, v.iv, v.d, v.c, v.ordy);
        @(negedge clk);
        n_vec++;
        if (use_b) begin
            ir = b_in_ready; ov = b_out_valid; od = b_out_data; oc = b_out_ctrl; cnt = b_stall_cnt;
        end else begin
            ir = a_in_ready; ov = a_out_valid; od = a_out_data; oc = a_out_ctrl; cnt = a_stall_cnt;
        end
        check($sformatf("%s[%0d].in_ready", tag, idx), 64'(ir), 64'(v.ir));
        check($sformatf("%s[%0d].out_valid", tag, idx), 64'(ov), 64'(v.ov));
        check($sformatf("%s[%0d].out_data", tag, idx), 64'(od), 64'(v.od));
        check($sformatf("%s[%0d].out_ctrl", tag, idx), 64'(oc), 64'(v.oc));
        check($sformatf("%s[%0d].stall_cnt", tag, idx), 64'(cnt), 64'(v.cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

        // SKID=1 table: rst,flush,iv,d,c,ordy | in_ready,out_valid,out_data,out_ctrl,stall_cnt
        // stream 1..4
        va.push_back(mk(0, 0, 1, 'h1,  'h11, 1,  1, 0, 'h0, 'h0,  0));
        va.push_back(mk(0, 0, 1, 'h2,  'h22, 1,  1, 1, 'h1, 'h11, 0));
        va.push_back(mk(0, 0, 1, 'h3,  'h33, 1,  1, 1, 'h2, 'h22, 0));
        va.push_back(mk(0, 0, 1, 'h4,  'h44, 1,  1, 1, 'h3, 'h33, 0));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  1,  1, 1, 'h4, 'h44, 0));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  1,  1, 0, 'h4, 'h0,  0));
        // backpressure A, B, C
        va.push_back(mk(0, 0, 1, 'hA,  'h0A, 0,  1, 0, 'h4, 'h0,  0));
        va.push_back(mk(0, 0, 1, 'hB,  'h0B, 0,  1, 1, 'hA, 'h0A, 0));
        va.push_back(mk(0, 0, 1, 'hC,  'h0C, 0,  0, 1, 'hA, 'h0A, 1));
        va.push_back(mk(0, 0, 1, 'hC,  'h0C, 0,  0, 1, 'hA, 'h0A, 2));
        va.push_back(mk(0, 0, 1, 'hC,  'h0C, 1,  0, 1, 'hA, 'h0A, 3));
        va.push_back(mk(0, 0, 1, 'hC,  'h0C, 1,  1, 1, 'hB, 'h0B, 3));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  1,  1, 1, 'hC, 'h0C, 3));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  0,  1, 0, 'hC, 'h0,  3));
        // fill to TWO, flush, offer an entry during a flush
        va.push_back(mk(0, 0, 1, 'h10, 'hFFFFFF, 0,  1, 0, 'hC,  'h0,      3));
        va.push_back(mk(0, 0, 1, 'h11, 'hFFFFFF, 0,  1, 1, 'h10, 'hFFFFFF, 3));
        va.push_back(mk(0, 1, 1, 'h12, 'hFFFFFF, 0,  0, 1, 'h10, 'hFFFFFF, 4));
        va.push_back(mk(0, 1, 1, 'h13, 'hFFFFFF, 1,  1, 0, 'h10, 'h0,      5));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,      1,  1, 0, 'h10, 'h0,      5));
        // flush + accept + release in one cycle
        va.push_back(mk(0, 0, 1, 'h20, 'h20, 1,  1, 0, 'h10, 'h0,  5));
        va.push_back(mk(0, 1, 1, 'h21, 'h21, 1,  1, 1, 'h20, 'h20, 5));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  1,  1, 0, 'h20, 'h0,  5));
        // reset while holding an entry
        va.push_back(mk(0, 0, 1, 'h30, 'h30, 0,  1, 0, 'h20, 'h0,  5));
        va.push_back(mk(1, 0, 1, 'h31, 'h31, 0,  1, 1, 'h30, 'h30, 5));
        va.push_back(mk(0, 0, 0, 'h0,  'h0,  0,  1, 0, 'h0,  'h0,  0));

        // SKID=0 table
        vb.push_back(mk(0, 0, 1, 'hA,  'h0A, 0,  1, 0, 'h0,  'h0,  0));
        vb.push_back(mk(0, 0, 1, 'hB,  'h0B, 0,  0, 1, 'hA,  'h0A, 0));
        vb.push_back(mk(0, 0, 1, 'hB,  'h0B, 0,  0, 1, 'hA,  'h0A, 1));
        vb.push_back(mk(0, 0, 1, 'hB,  'h0B, 1,  1, 1, 'hA,  'h0A, 2));
        vb.push_back(mk(0, 0, 1, 'hC,  'h0C, 1,  1, 1, 'hB,  'h0B, 2));
        vb.push_back(mk(0, 0, 0, 'h0,  'h0,  0,  0, 1, 'hC,  'h0C, 2));
        vb.push_back(mk(0, 0, 0, 'h0,  'h0,  1,  1, 1, 'hC,  'h0C, 3));
        vb.push_back(mk(0, 0, 0, 'h0,  'h0,  0,  1, 0, 'hC,  'h0,  3));
        vb.push_back(mk(0, 0, 1, 'h40, 'hFFFFFF, 0,  1, 0, 'hC,  'h0,      3));
        vb.push_back(mk(0, 1, 1, 'h41, 'hFFFFFF, 0,  0, 1, 'h40, 'hFFFFFF, 3));
        vb.push_back(mk(0, 0, 0, 'h0,  'h0,      0,  1, 0, 'h40, 'h0,      4));

        do_reset();
        foreach (va[i]) run_row(va[i], 1'b0, "skid", i);

        do_reset();
        foreach (vb[i]) run_row(vb[i], 1'b1, "noskid", i);

        // Counter saturation: one held entry, 20 stalled cycles.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 'h50, 'h5, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        n_vec++;
        check("sat.c_cnt_at_15", 64'(c_stall_cnt), 64'd15);
        check("sat.a_cnt_at_15", 64'(a_stall_cnt), 64'd15);
        check("sat.c_out_valid", 64'(c_out_valid), 64'd1);
        check("sat.c_out_data", 64'(c_out_data), 64'h50);
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_vec++;
        check("sat.c_cnt_held", 64'(c_stall_cnt), 64'd15);
        check("sat.a_cnt_at_20", 64'(a_stall_cnt), 64'd20);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        n_vec++;
        check("sat.c_cnt_after_rst", 64'(c_stall_cnt), 64'd0);
        check("sat.c_valid_after_rst", 64'(c_out_valid), 64'd0);
        check("sat.c_ready_after_rst", 64'(c_in_ready), 64'd1);
        check("sat.c_data_after_rst", 64'(c_out_data), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generic successor to the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V multi-cycle pipelined processor. It carries a payload bus and a separately handled control-bit bus. It adds a valid/ready handshake for stalls, a synchronous flush for bubble insertion, an optional 2-entry skid buffer that registers the upstream ready, and a saturating stall-cycle counter. Each processor stage boundary instantiates one copy with its own widths.

## Interface
- DATA_W, 192: payload width (e.g. inst 32 + pc 32 + ALU result 64 + rs2 data 64).
- CTRL_W, 24: control-bit width (MemWrite, MemRead, RegWrite, MemtoReg, branch/jump flags, wmask, …). Forced to 0 in bubbles.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: stall counter width.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill every held entry; takes effect at the next edge.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  out_data/out_ctrl hold a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control of the head entry; all-zero whenever out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid & in_ready & !flush. Release: out_valid & out_ready & !flush.
- SKID=1 states (shared enum): EMPTY (no entries), ONE (main full), TWO (main + skid full).
  - EMPTY: accept → ONE.
  - ONE: accept & no release → TWO (entry to skid). Release & no accept → EMPTY. Both → ONE (main reloads). Neither → hold.
  - TWO: release → ONE (skid moves to main). No accept is possible.
- SKID=1 output: in_ready = (state != TWO), a register output.
- SKID=0: one register. in_ready = !out_valid | out_ready. Accept loads the register. Release without accept empties it.
- Any state with flush=1 → EMPTY next cycle. The entry presented on in_data in the flush cycle is dropped, even if in_ready=1. out_ctrl is 0 from the next cycle.
- Bubble rule: an invalid entry always drives out_ctrl = 0. out_data is not cleared on release or flush; it keeps its last value, and consumers must qualify it with out_valid.
- Ordering is strict FIFO. Entries are never duplicated or reordered.
- stall_cnt increments by 1 each cycle out_valid & !out_ready. It saturates at 2^CNT_W−1. It is cleared only by rst; flush does not clear it.

## Timing
- rst=1 at an edge: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0. in_ready=1 from the following cycle in both modes.
- rst overrides flush and all handshakes. Asserting rst mid-stall discards all entries.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle).
- Throughput: 1 entry/cycle while out_ready=1.
- SKID=1: in_ready deasserts the cycle after the skid fills. in_ready reasserts the cycle after the first release from TWO.
- SKID=0: a stall (out_ready=0) with out_valid=1 drops in_ready in the same cycle.
- Simultaneous accept and flush: flush wins; the stage is empty next cycle.
- Simultaneous release and flush: the released entry counts as consumed by downstream; the stage is empty next cycle.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY/ONE/TWO);
  - the control-field bit positions inside in_ctrl;
  - the processor's ALUop, funct3/funct7 and opcode constants, so every stage decodes ctrl consistently.
- One sub-module, pipe_skid_buf, holds the SKID=1 storage and state machine. It is instantiated under a generate on SKID.
- The top level keeps the SKID=0 path, the bubble masking and stall_cnt.

## Test plan
- Reset then stream: rst 2 cycles, then in_data=1,2,3,4 on consecutive cycles with out_ready=1 → out_data 1,2,3,4, each one cycle later, out_valid continuous, stall_cnt=0.
- Backpressure, SKID=1: out_ready=0 while feeding 0xA, 0xB, 0xC → in_ready falls after 0xB is stored. 0xC is not accepted until the cycle after out_ready=1. Output order is A, B, C; stall_cnt equals the number of stalled cycles.
- Backpressure, SKID=0: same stimulus → in_ready=0 in the same cycle as out_ready=0 with out_valid=1. No loss, order A, B, C.
- Flush while full (TWO): in_ctrl=0xFFFFFF entries, flush=1 for one cycle → next cycle out_valid=0, out_ctrl=0. An entry offered in the flush cycle never appears.
- Flush + accept + release in the same cycle → empty next cycle. The released entry is observed exactly once.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15. Then assert rst → 0 after the edge.
